// File: rtl/vec_add_pkg.sv
// Shared definitions for the vec_add streaming fp32 adder:
// control FSM states, fp32 field layout and a leading-zero counter
// used by the adder's normalize stage.
package vec_add_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_ADD,
        ST_WRITE,
        ST_WRITE_EOT,
        ST_DONE
    } state_t;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = '1;
    localparam logic [31:0]         FP32_QNAN  = 32'h7FC00000;

    // Number of leading zeros in a 27-bit significand (hidden + mantissa + G/R/S).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] cnt;
        logic       found;
        cnt   = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    cnt = cnt + 5'd1;
                end
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fp32_add.sv
// Pipelined IEEE-754 single-precision adder.
// Stage 1: unpack, special-case detection, operand swap and alignment.
// Stage 2: add/subtract and normalize.
// Stage 3: round-to-nearest-even and pack.
// Subnormals flush to signed zero, NaN results are canonical, overflow gives inf.
// The pipeline only advances while 'en' is high so the result holds afterwards.
// Depths above three are padded with plain delay stages; below three is unsupported.
module fp32_add
    import vec_add_pkg::*;
#(
    parameter int ADD_LAT = 3
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    // hidden bit + mantissa + guard, round, sticky
    localparam int SIG_W = FP_MAN_W + 4;

    // ---------------- stage 1: unpack / specials / align ----------------
    logic                a_sign, b_sign;
    logic [FP_EXP_W-1:0] a_exp, b_exp;
    logic [FP_MAN_W-1:0] a_man, b_man;
    logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                swap;
    logic                big_sign;
    logic [FP_EXP_W-1:0] big_exp, small_exp, exp_diff;
    logic [FP_MAN_W-1:0] big_man, small_man;
    logic [4:0]          shamt;
    logic [SIG_W-1:0]    big_sig, small_sig, small_aln;
    logic [SIG_W+31:0]   wide;
    logic                s1_special_d;
    logic [31:0]         s1_val_d;

    assign a_sign = a[31];
    assign a_exp  = a[30:23];
    assign a_man  = a[22:0];
    assign b_sign = b[31];
    assign b_exp  = b[30:23];
    assign b_man  = b[22:0];

    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == FP_EXP_MAX) && (a_man == '0);
    assign b_inf  = (b_exp == FP_EXP_MAX) && (b_man == '0);
    assign a_nan  = (a_exp == FP_EXP_MAX) && (a_man != '0);
    assign b_nan  = (b_exp == FP_EXP_MAX) && (b_man != '0);

    assign swap      = {b_exp, b_man} > {a_exp, a_man};
    assign big_sign  = swap ? b_sign : a_sign;
    assign big_exp   = swap ? b_exp  : a_exp;
    assign big_man   = swap ? b_man  : a_man;
    assign small_exp = swap ? a_exp  : b_exp;
    assign small_man = swap ? a_man  : b_man;

    assign big_sig   = {1'b1, big_man, 3'b000};
    assign small_sig = {1'b1, small_man, 3'b000};
    assign exp_diff  = big_exp - small_exp;
    assign shamt     = (exp_diff > 8'd31) ? 5'd31 : exp_diff[4:0];
    assign wide      = {small_sig, 32'b0} >> shamt;
    assign small_aln = wide[SIG_W+31:32] | {{(SIG_W-1){1'b0}}, |wide[31:0]};

    // Resolve NaN/inf/zero operands up front so later stages just pass them through
    always_comb begin
        s1_special_d = 1'b1;
        s1_val_d     = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
            s1_val_d = FP32_QNAN;
        end else if (a_inf) begin
            s1_val_d = {a_sign, FP_EXP_MAX, {FP_MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_val_d = {b_sign, FP_EXP_MAX, {FP_MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            s1_val_d = {a_sign & b_sign, 31'b0};
        end else if (a_zero) begin
            s1_val_d = b;
        end else if (b_zero) begin
            s1_val_d = a;
        end else begin
            s1_special_d = 1'b0;
        end
    end

    logic                s1_special;
    logic [31:0]         s1_val;
    logic                s1_sign, s1_sub;
    logic [FP_EXP_W-1:0] s1_exp;
    logic [SIG_W-1:0]    s1_big, s1_small;

    // Stage 1 register: aligned operands ordered by magnitude
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_special <= 1'b0;
            s1_val     <= '0;
            s1_sign    <= 1'b0;
            s1_sub     <= 1'b0;
            s1_exp     <= '0;
            s1_big     <= '0;
            s1_small   <= '0;
        end else if (en) begin
            s1_special <= s1_special_d;
            s1_val     <= s1_val_d;
            s1_sign    <= big_sign;
            s1_sub     <= a_sign ^ b_sign;
            s1_exp     <= big_exp;
            s1_big     <= big_sig;
            s1_small   <= small_aln;
        end
    end

    // ---------------- stage 2: add/sub and normalize ----------------
    logic [SIG_W:0]    raw;
    logic [4:0]        lz;
    logic              s2_special_d;
    logic [31:0]       s2_val_d;
    logic signed [9:0] s2_exp_d;
    logic [SIG_W-1:0]  s2_norm_d;

    assign raw = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                        : ({1'b0, s1_big} + {1'b0, s1_small});
    assign lz  = lzc27(raw[SIG_W-1:0]);

    // Bring the leading one to the hidden-bit position, keeping sticky on right shifts
    always_comb begin
        s2_special_d = s1_special;
        s2_val_d     = s1_val;
        s2_exp_d     = '0;
        s2_norm_d    = '0;
        if (!s1_special) begin
            if (raw == '0) begin
                s2_special_d = 1'b1;
                s2_val_d     = '0;
            end else if (raw[SIG_W]) begin
                s2_norm_d = {raw[SIG_W:2], raw[1] | raw[0]};
                s2_exp_d  = $signed({2'b00, s1_exp}) + 10'sd1;
            end else begin
                s2_norm_d = raw[SIG_W-1:0] << lz;
                s2_exp_d  = $signed({2'b00, s1_exp}) - $signed({5'b00000, lz});
            end
            if ((raw != '0) && (s2_exp_d <= 10'sd0)) begin
                s2_special_d = 1'b1;
                s2_val_d     = {s1_sign, 31'b0};
            end
        end
    end

    logic              s2_special;
    logic [31:0]       s2_val;
    logic              s2_sign;
    logic signed [9:0] s2_exp;
    logic [SIG_W-1:0]  s2_norm;

    // Stage 2 register: normalized significand and biased exponent
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s2_special <= 1'b0;
            s2_val     <= '0;
            s2_sign    <= 1'b0;
            s2_exp     <= '0;
            s2_norm    <= '0;
        end else if (en) begin
            s2_special <= s2_special_d;
            s2_val     <= s2_val_d;
            s2_sign    <= s1_sign;
            s2_exp     <= s2_exp_d;
            s2_norm    <= s2_norm_d;
        end
    end

    // ---------------- stage 3: round and pack ----------------
    logic [23:0]       mant24;
    logic              rnd_up;
    logic [24:0]       mant_r;
    logic signed [9:0] exp_r;
    logic [22:0]       man_f;
    logic [31:0]       res_d;

    assign mant24 = s2_norm[SIG_W-1:3];
    assign rnd_up = s2_norm[2] & (s2_norm[1] | s2_norm[0] | mant24[0]);
    assign mant_r = {1'b0, mant24} + {24'b0, rnd_up};
    assign exp_r  = mant_r[24] ? (s2_exp + 10'sd1) : s2_exp;
    assign man_f  = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    // Pack the final word, saturating exponent overflow to infinity
    always_comb begin
        res_d = '0;
        if (s2_special) begin
            res_d = s2_val;
        end else if (exp_r >= 10'sd255) begin
            res_d = {s2_sign, FP_EXP_MAX, {FP_MAN_W{1'b0}}};
        end else begin
            res_d = {s2_sign, exp_r[7:0], man_f};
        end
    end

    logic [31:0] res_q;

    // Stage 3 register: packed fp32 result
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            res_q <= '0;
        end else if (en) begin
            res_q <= res_d;
        end
    end

    generate
        if (ADD_LAT > 3) begin : g_extra
            logic [31:0] dly_q [ADD_LAT-3];

            // Padding stages for deeper pipeline configurations
            always_ff @(posedge ap_clk or posedge ap_rst) begin
                if (ap_rst) begin
                    for (int i = 0; i < ADD_LAT-3; i++) begin
                        dly_q[i] <= '0;
                    end
                end else if (en) begin
                    dly_q[0] <= res_q;
                    for (int i = 1; i < ADD_LAT-3; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign sum = dly_q[ADD_LAT-4];
        end else begin : g_base
            assign sum = res_q;
        end
    endgenerate

endmodule

// File: rtl/vec_add.sv
// Streaming fp32 vector adder kernel with an HLS-style block control interface.
// Pops one pair from a_s/b_s, adds it in fp32_add, pushes the sum to c, and
// repeats until an EOT head is popped, which is forwarded to c before done.
// Handshake strobes are combinational from state and the FIFO flags so a
// pop or push can never happen against an empty or full FIFO.
module vec_add
    import vec_add_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADD_LAT = 3
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_ready,
    output logic              ap_idle,
    input  logic [63:0]       n,
    input  logic [DATA_W-1:0] a_s_dout,
    input  logic              a_s_dout_eot,
    input  logic              a_s_empty_n,
    output logic              a_s_read,
    input  logic [DATA_W-1:0] b_s_dout,
    input  logic              b_s_dout_eot,
    input  logic              b_s_empty_n,
    output logic              b_s_read,
    output logic [DATA_W-1:0] c_din,
    output logic              c_din_eot,
    input  logic              c_full_n,
    output logic              c_write
);

    localparam int CNT_W = $clog2(ADD_LAT + 1);

    state_t              state;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [63:0]         n_unused_q;
    logic [CNT_W-1:0]    lat_cnt;
    logic [DATA_W-1:0]   sum;
    logic                pop;
    logic                add_en;

    assign pop    = (state == ST_READ) && a_s_empty_n && b_s_empty_n;
    assign add_en = (state == ST_ADD);

    fp32_add #(
        .ADD_LAT (ADD_LAT)
    ) u_add (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .en     (add_en),
        .a      (a_q),
        .b      (b_q),
        .sum    (sum)
    );

    // Control FSM: one element per pass through READ -> ADD -> WRITE
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            n_unused_q <= '0;
            lat_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        n_unused_q <= n;
                        state      <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (pop) begin
                        a_q     <= a_s_dout;
                        b_q     <= b_s_dout;
                        lat_cnt <= '0;
                        state   <= (a_s_dout_eot || b_s_dout_eot) ? ST_WRITE_EOT : ST_ADD;
                    end
                end
                ST_ADD: begin
                    if (lat_cnt == CNT_W'(ADD_LAT - 1)) begin
                        state <= ST_WRITE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (c_full_n) begin
                        state <= ST_READ;
                    end
                end
                ST_WRITE_EOT: begin
                    if (c_full_n) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ap_idle   = (state == ST_IDLE);
    assign ap_done   = (state == ST_DONE);
    assign ap_ready  = (state == ST_DONE);
    assign a_s_read  = pop;
    assign b_s_read  = pop;
    assign c_write   = ((state == ST_WRITE) || (state == ST_WRITE_EOT)) && c_full_n;
    assign c_din     = (state == ST_WRITE) ? sum : '0;
    assign c_din_eot = (state == ST_WRITE_EOT);

endmodule

// File: tb/tb_vec_add.sv
// Testbench for vec_add: FIFO source/sink models around the DUT and a
// scoreboard of expected c tokens filled when stimulus is queued.
module tb_vec_add;

    localparam int ADD_LAT = 3;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done, ap_ready, ap_idle;
    logic [63:0] n;
    logic [31:0] a_s_dout = '0;
    logic        a_s_dout_eot = 1'b0;
    logic        a_s_empty_n = 1'b0;
    logic        a_s_read;
    logic [31:0] b_s_dout = '0;
    logic        b_s_dout_eot = 1'b0;
    logic        b_s_empty_n = 1'b0;
    logic        b_s_read;
    logic [31:0] c_din;
    logic        c_din_eot;
    logic        c_full_n = 1'b1;
    logic        c_write;

    always #5 ap_clk = ~ap_clk;

    vec_add #(
        .DATA_W  (32),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .ap_start     (ap_start),
        .ap_done      (ap_done),
        .ap_ready     (ap_ready),
        .ap_idle      (ap_idle),
        .n            (n),
        .a_s_dout     (a_s_dout),
        .a_s_dout_eot (a_s_dout_eot),
        .a_s_empty_n  (a_s_empty_n),
        .a_s_read     (a_s_read),
        .b_s_dout     (b_s_dout),
        .b_s_dout_eot (b_s_dout_eot),
        .b_s_empty_n  (b_s_empty_n),
        .b_s_read     (b_s_read),
        .c_din        (c_din),
        .c_din_eot    (c_din_eot),
        .c_full_n     (c_full_n),
        .c_write      (c_write)
    );

    logic [32:0] src_a[$];
    logic [32:0] src_b[$];
    logic [32:0] exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pop_req = 0;
    int pop_done = 0;
    int wr_req = 0;
    int wr_done = 0;
    int pop_cyc = 0;
    int bubble_cnt = 0;
    bit bp_mode = 1'b0;
    bit bubble_mode = 1'b0;
    bit lat_mode = 1'b0;
    logic        prev_full_n = 1'b1;
    logic [32:0] prev_out = '0;

    logic [31:0] nom_a [5] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] nom_b [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    logic [31:0] nom_c [5] = '{32'h3F800000, 32'h40400000, 32'h40A00000, 32'h40E00000, 32'h41100000};

    localparam int NSPEC = 13;
    logic [31:0] sp_a [NSPEC] = '{32'h7F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800001,
                                  32'h80000000, 32'h80000001, 32'h3F800000, 32'h3F800001,
                                  32'h3FC00000, 32'h40000000, 32'hFF7FFFFF, 32'h7F800000,
                                  32'h3F800000};
    logic [31:0] sp_b [NSPEC] = '{32'hFF800000, 32'hBF800000, 32'h7F7FFFFF, 32'h3F800000,
                                  32'h80000000, 32'h80000001, 32'h33800000, 32'h33800000,
                                  32'hBF000000, 32'hC0400000, 32'hFF7FFFFF, 32'h3F800000,
                                  32'h3F800000};
    logic [31:0] sp_c [NSPEC] = '{32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h7FC00000,
                                  32'h80000000, 32'h80000000, 32'h3F800000, 32'h3F800002,
                                  32'h3F800000, 32'hBF800000, 32'hFF800000, 32'h7F800000,
                                  32'h40000000};

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] want, input bit eot_a, input bit eot_b);
        src_a.push_back({eot_a, a});
        src_b.push_back({eot_b, b});
        if (eot_a || eot_b) begin
            exp_q.push_back({1'b1, 32'h0});
        end else begin
            exp_q.push_back({1'b0, want});
        end
    endtask

    task automatic load_nominal();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(nom_a[i], nom_b[i], nom_c[i], 1'b0, 1'b0);
        end
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic run_vector(input int max_cycles);
        bit got_done;
        got_done = 1'b0;
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        checkOutput("idle_busy", 64'(ap_idle), 64'd0);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                got_done = 1'b1;
                checkOutput("ready_pulse", 64'(ap_ready), 64'd1);
                break;
            end
        end
        checkOutput("done_seen", 64'(got_done), 64'd1);
        if (got_done) begin
            @(negedge ap_clk);
            checkOutput("done_width", 64'({ap_done, ap_ready}), 64'd0);
            checkOutput("idle_after", 64'(ap_idle), 64'd1);
        end
        checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("src_drained", 64'(src_a.size() + src_b.size()), 64'd0);
        exp_q.delete();
        src_a.delete();
        src_b.delete();
    endtask

    // Source/sink model: apply pops, bubbles and backpressure just after each edge
    always @(posedge ap_clk) begin
        cyc = cyc + 1;
        #1;
        while (pop_done < pop_req) begin
            if (src_a.size() > 0) void'(src_a.pop_front());
            if (src_b.size() > 0) void'(src_b.pop_front());
            pop_done++;
        end
        if (bubble_cnt > 0) bubble_cnt--;
        while (wr_done < wr_req) begin
            if (bubble_mode) bubble_cnt = 3;
            wr_done++;
        end
        if (bp_mode) begin
            c_full_n = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        end else begin
            c_full_n = 1'b1;
        end
        if ((src_a.size() > 0) && (bubble_cnt == 0)) begin
            a_s_empty_n  = 1'b1;
            a_s_dout     = src_a[0][31:0];
            a_s_dout_eot = src_a[0][32];
        end else begin
            a_s_empty_n  = 1'b0;
            a_s_dout     = '0;
            a_s_dout_eot = 1'b0;
        end
        if (src_b.size() > 0) begin
            b_s_empty_n  = 1'b1;
            b_s_dout     = src_b[0][31:0];
            b_s_dout_eot = src_b[0][32];
        end else begin
            b_s_empty_n  = 1'b0;
            b_s_dout     = '0;
            b_s_dout_eot = 1'b0;
        end
    end

    // Monitor: handshake legality, scoreboard compare, latency and stall stability
    always @(negedge ap_clk) begin
        logic [32:0] want;
        if (ap_rst) begin
            prev_out    = '0;
            prev_full_n = 1'b1;
        end else begin
            if (a_s_read || b_s_read) begin
                checkOutput("rd_pair", 64'({a_s_read, b_s_read}), 64'd3);
                checkOutput("rd_valid", 64'({a_s_empty_n, b_s_empty_n}), 64'd3);
                pop_req++;
                pop_cyc = cyc;
            end
            if (c_write) begin
                checkOutput("wr_full", 64'(c_full_n), 64'd1);
                checkOutput("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    checkOutput("c_token", 64'({c_din_eot, c_din}), 64'(want));
                    if (lat_mode && !want[32]) begin
                        checkOutput("latency", 64'(cyc - pop_cyc), 64'(ADD_LAT + 1));
                    end
                end
                wr_req++;
            end
            if (!prev_full_n && (prev_out != '0)) begin
                checkOutput("stall_hold", 64'({c_din_eot, c_din}), 64'(prev_out));
            end
            prev_full_n = c_full_n;
            prev_out    = {c_din_eot, c_din};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=expired want=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        n        = 64'd5;
        repeat (3) @(negedge ap_clk);
        checkOutput("rst_outputs", 64'({ap_done, ap_ready, a_s_read, b_s_read, c_write, c_din_eot, c_din}), 64'd0);
        checkOutput("rst_idle", 64'(ap_idle), 64'd1);
        ap_rst = 1'b0;

        $display("[TB] nominal run");
        lat_mode = 1'b1;
        load_nominal();
        run_vector(200);

        $display("[TB] backpressure run");
        lat_mode = 1'b0;
        bp_mode  = 1'b1;
        load_nominal();
        run_vector(400);
        bp_mode = 1'b0;

        $display("[TB] input bubble run");
        bubble_mode = 1'b1;
        load_nominal();
        run_vector(400);
        bubble_mode = 1'b0;

        $display("[TB] empty vector");
        applyStimulus(32'h00001234, 32'h00005678, 32'h0, 1'b1, 1'b1);
        run_vector(50);

        $display("[TB] EOT on stream a only");
        applyStimulus(32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
        applyStimulus(32'h0, 32'h40000000, 32'h0, 1'b1, 1'b0);
        run_vector(100);

        $display("[TB] special values");
        lat_mode = 1'b1;
        for (int i = 0; i < NSPEC; i++) begin
            applyStimulus(sp_a[i], sp_b[i], sp_c[i], 1'b0, 1'b0);
        end
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        run_vector(400);

        $display("[TB] reset during ADD");
        load_nominal();
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        checkOutput("rst_pop_seen", 64'(a_s_read), 64'd1);
        @(posedge ap_clk);
        #2;
        ap_rst = 1'b1;
        #1;
        checkOutput("midrst_outputs", 64'({ap_done, ap_ready, a_s_read, b_s_read, c_write, c_din_eot, c_din}), 64'd0);
        checkOutput("midrst_idle", 64'(ap_idle), 64'd1);
        src_a.delete();
        src_b.delete();
        exp_q.delete();
        repeat (2) @(negedge ap_clk);
        checkOutput("midrst_hold", 64'({ap_idle, a_s_read, c_write}), 64'd4);
        ap_rst = 1'b0;

        $display("[TB] nominal run after reset");
        load_nominal();
        run_vector(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_add.md
# vec_add

Streaming single-precision vector adder with an HLS-style block-level control interface. It pops element pairs from two FIFO-read input streams `a_s` and `b_s` and pushes their IEEE-754 sums to a FIFO-write output stream `c`. It stops when the end-of-transaction (EOT) token arrives and forwards that token to `c`. It is the top-level compute kernel of the stream-top dataflow, with its streams connected directly to upstream and downstream FIFOs.

## Interface
Parameters:
- `DATA_W`, 32: stream payload width. Fixed at 32 for fp32.
- `ADD_LAT`, 3: adder pipeline depth in cycles.

Ports:
- `ap_clk` in 1: the only clock; all logic on its rising edge.
- `ap_rst` in 1: reset, asynchronous, active-high.
- `ap_start` in 1: level start request.
- `ap_done` out 1: one-cycle pulse when the run completes.
- `ap_ready` out 1: one-cycle pulse, coincident with `ap_done`.
- `ap_idle` out 1: high while no run is active.
- `n` in 64: element-count hint. Latched at start, reserved, never used for termination.
- `a_s_dout` in 32: head data of stream a.
- `a_s_dout_eot` in 1: head of stream a is the EOT token.
- `a_s_empty_n` in 1: stream a head is valid.
- `a_s_read` out 1: pops the stream a head this cycle.
- `b_s_dout`, `b_s_dout_eot`, `b_s_empty_n` in; `b_s_read` out: same roles for stream b.
- `c_din` out 32: output data.
- `c_din_eot` out 1: output token is EOT.
- `c_full_n` in 1: output FIFO can accept a token.
- `c_write` out 1: pushes `c_din`/`c_din_eot` this cycle.

## Operation
- FSM states: IDLE, READ, ADD, WRITE, WRITE_EOT, DONE.
- IDLE: `ap_idle`=1. When `ap_start`=1, latch `n` and go to READ.
- READ: wait until `a_s_empty_n && b_s_empty_n`.
  - Then pulse `a_s_read` and `b_s_read` together for one cycle and register both heads.
  - If either head's EOT flag is set, go to WRITE_EOT. Both heads are consumed regardless of payload.
  - Otherwise go to ADD.
- ADD: fp32 add in `ADD_LAT` cycles, then go to WRITE.
  - Rounding is round-to-nearest-even.
  - Subnormal inputs and results flush to signed zero.
  - Any NaN input, or inf + (−inf), yields canonical NaN 0x7FC00000.
  - Overflow yields ±inf.
  - Exact zero results are +0, except (−0)+(−0) = −0.
- WRITE: hold `c_din` = sum and `c_din_eot`=0. Assert `c_write` only in a cycle where `c_full_n`=1, then return to READ.
- WRITE_EOT: hold `c_din`=0 and `c_din_eot`=1. Assert `c_write` in the first cycle with `c_full_n`=1, then go to DONE.
- DONE: pulse `ap_done` and `ap_ready` for one cycle, then return to IDLE.
- Result order equals input order. There is exactly one output token per consumed input pair, plus one EOT token.

## Timing
- Reset (asynchronous assert, synchronous deassert at the boundary): state IDLE.
  - `ap_idle`=1.
  - `ap_done`, `ap_ready`, `a_s_read`, `b_s_read`, `c_write`, `c_din_eot` = 0; `c_din`=0.
- Reset asserted mid-run aborts immediately with no further pops or pushes. Partially consumed inputs are lost.
- `*_read` and `c_write` are each combinational from state plus the corresponding `empty_n`/`full_n`. No read ever occurs while `empty_n`=0. No write ever occurs while `full_n`=0.
- `c_write` is only ever asserted together with `c_full_n`=1.
- `c_din`/`c_din_eot` are stable throughout WRITE/WRITE_EOT, including stalled cycles.
- Input-pop to output-push latency is `ADD_LAT`+1 cycles with no backpressure. Throughput is one element per `ADD_LAT`+2 cycles; no overlap between elements is required.
- `ap_start` held high after `ap_done` starts a new run on the next cycle.

## Structure
- Shared package `vec_add_pkg`:
  - FSM state enum.
  - fp32 field widths (8-bit exponent, 23-bit mantissa, bias 127).
  - `FP32_QNAN` = 32'h7FC00000.
- One sub-module, `fp32_add`: pipelined adder with `ADD_LAT` stages that performs align, add/subtract, normalize and round. Top level is control plus stream handshakes only.

## Test plan
- Nominal: a = 0,1,2,3,4 and b = 1,2,3,4,5 (fp32), then EOT on both, `c_full_n`=1 → c = 3F800000, 40400000, 40A00000, 40E00000, 41100000. Next token has `c_din_eot`=1, then an `ap_done`/`ap_ready` pulse.
- Backpressure: same data with `c_full_n` toggling 1-0-0-1 → no `c_write` while `c_full_n`=0; values and order unchanged; `c_din` stable during stalls.
- Input bubbles: `a_s_empty_n` dropping for 3 cycles between elements while b stays ready → no pops in those cycles, and both streams are popped in the same cycle.
- Empty vector: EOT is the first token on both streams → single c token with `c_din_eot`=1 and `c_din`=0, then done.
- Special values: 7F800000 + FF800000 → 7FC00000; 3F800000 + BF800000 → 00000000; 7F7FFFFF + 7F7FFFFF → 7F800000.
- Reset mid-run: assert `ap_rst` during ADD → all handshake outputs 0 and `ap_idle`=1 immediately; a fresh nominal run afterwards passes.
